seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 7 +
 rtl/chunk_adder.sv | 19 +
 rtl/full_adder.sv | 11 +
 rtl/seq_chunk_adder.sv | 87 ++++++++
 tb/tb_seq_chunk_adder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared FSM state type and counter sizing helper.
package seq_chunk_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] s_o,
   output logic             c_o,
   output logic             cm_o
);
   logic [CHUNK:0] c;
   assign c[0] = c_i;
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(s_o[i]), .c_o(c[i+1]));
   end
   assign c_o  = c[CHUNK];
   assign cm_o = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor, one CHUNK-bit slice per cycle, LSB first.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = cnt_width(NCHUNK);
   if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, s_q;
   logic             c_q, cout_q, ovf_q;
   logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
   logic             co_sl, cm_sl, last;
   always_comb begin
      a_sl = a_q[int'(cnt_q)*CHUNK +: CHUNK];
      b_sl = b_q[int'(cnt_q)*CHUNK +: CHUNK];
      acc_d = acc_q;
      acc_d[int'(cnt_q)*CHUNK +: CHUNK] = sum_sl;
   end
   assign last = cnt_q == CW'(NCHUNK - 1);
   chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a_i(a_sl), .b_i(b_sl), .c_i(c_q), .s_o(sum_sl), .c_o(co_sl), .cm_o(cm_sl)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               acc_q <= acc_d;
               c_q   <= co_sl;
               if (last) begin
                  s_q     <= acc_d;
                  cout_q  <= co_sl;
                  ovf_q   <= co_sl ^ cm_sl;
                  state_q <= DONE;
               end else
                  cnt_q <= cnt_q + 1'b1;
            end
            IDLE, DONE: begin
               if (start) begin
                  // b is stored inverted for subtract so RUN only ever adds
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  c_q     <= sub | cin;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  state_q <= RUN;
               end else
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed vectors with a cycle-level arithmetic model checked every cycle.
module tb_seq_chunk_adder;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, cin = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic busy, done, cout, ovf;
   logic [15:0] s;
   logic start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic busy8, done8, cout8, ovf8;
   logic [7:0] s8;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
   );
   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
      .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // Model: an accepted op produces a+b' +c exactly 4 RUN cycles later, then one DONE cycle.
   int rem = 0;
   logic mvalid = 1'b0, m_done = 1'b0, m_c = 1'b0, m_o = 1'b0, p_c = 1'b0, p_o = 1'b0, fin;
   logic [15:0] m_s = '0, p_s = '0, bb;
   logic [16:0] tot;
   always @(posedge clk) begin
      if (!rst_n) begin
         rem = 0; m_done = 0; m_s = '0; m_c = 0; m_o = 0;
      end else begin
         fin = (rem == 1);
         if (fin) begin m_s = p_s; m_c = p_c; m_o = p_o; end
         if (rem == 0 && start) begin
            bb = sub ? ~b : b;
            tot = {1'b0, a} + {1'b0, bb} + 17'(sub | cin);
            p_s = tot[15:0];
            p_c = tot[16];
            p_o = (a[15] == bb[15]) && (p_s[15] != a[15]);
            rem = 4;
         end else if (rem > 0)
            rem--;
         m_done = fin;
      end
      mvalid = 1'b1;
   end
   always @(negedge clk) if (mvalid) begin
      chk("m_busy", 32'(busy), 32'(rem > 0));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_s", 32'(s), 32'(m_s));
      chk("m_cout", 32'(cout), 32'(m_c));
      chk("m_ovf", 32'(ovf), 32'(m_o));
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(inout int n);
      while (!done && n < 12) begin step(); n++; end
   endtask
   task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
      a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
      step();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask
   task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts, input logic [15:0] es, input logic ec, input logic eo);
      int n;
      launch(ta, tb_, tc, ts);
      n = 1;
      chk({nm, "_busy1"}, 32'(busy), 1);
      wait_done(n);
      chk({nm, "_lat"}, n, 5);
      chk({nm, "_s"}, 32'(s), 32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
      step();
   endtask
   initial begin
      int n;
      logic seen;
      repeat (2) step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_s", 32'(s), 0);
      rst_n = 1'b1;
      step();
      run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("subneg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
      // start during RUN is ignored
      launch(16'h1111, 16'h2222, 1'b1, 1'b0);
      n = 1;
      step(); n++;
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      step(); n++;
      start = 1'b0;
      wait_done(n);
      chk("ign_lat", n, 5);
      chk("ign_s", 32'(s), 32'h3334);
      step();
      // back-to-back: start held in the DONE cycle
      launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      n = 1;
      wait_done(n);
      chk("b2b1_s", 32'(s), 32'h1000);
      launch(16'h2000, 16'h0001, 1'b0, 1'b1);
      n = 1;
      chk("b2b_hold", 32'(s), 32'h1000);
      wait_done(n);
      chk("b2b2_lat", n, 5);
      chk("b2b2_s", 32'(s), 32'h1FFF);
      chk("b2b2_cout", 32'(cout), 1);
      step();
      // reset in the second RUN cycle aborts the op
      launch(16'h0101, 16'h0202, 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_s", 32'(s), 0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin step(); seen |= done; end
      chk("abort_nodone", 32'(seen), 0);
      run_op("after", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
      // single-chunk instance
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      step();
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 12) begin step(); n++; end
      chk("w8_lat", n, 2);
      chk("w8_s", 32'(s8), 0);
      chk("w8_cout", 32'(cout8), 1);
      chk("w8_ovf", 32'(ovf8), 1);
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
